// File: rtl/branch_predictor_param.sv
// branch_predictor_param
// Parametrised branch direction predictor for the pipelined 10-bit CPU family.
// The fetch unit presents a PC and gets a taken/not-taken prediction in the
// same cycle. The decode stage later returns the resolved outcome, which
// trains a table of saturating counters. Indexing is either bimodal (PC bits)
// or gshare (PC bits xor global history). After reset or flush the table is
// swept back to weakly-not-taken, one entry per cycle, before o_ready rises.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   i_flush               pulse: clear history and restart the init sweep
//   i_clear_stats         pulse: zero the statistics counters
//   i_lookup_pc           fetch PC for the combinational prediction
//   o_prediction          1 = predict taken (always 0 while not ready)
//   o_ready               table initialised, predictions valid
//   i_update_valid        a resolved branch is presented this cycle
//   i_update_pc           PC of the resolved branch
//   i_update_taken        actual branch outcome
//   i_update_predicted    prediction that was used for this branch
//   o_ghr                 current global history register
//   o_update_count        accepted updates (saturating)
//   o_mispredict_count    accepted updates that were mispredicted (saturating)

module branch_predictor_param #(
    parameter int PC_WIDTH     = 10,
    parameter int INDEX_BITS   = 6,
    parameter int HIST_BITS    = 4,
    parameter int COUNTER_BITS = 2,
    parameter int MODE         = 1,
    parameter int STAT_BITS    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    input  logic                  i_clear_stats,
    input  logic [PC_WIDTH-1:0]   i_lookup_pc,
    output logic                  o_prediction,
    output logic                  o_ready,
    input  logic                  i_update_valid,
    input  logic [PC_WIDTH-1:0]   i_update_pc,
    input  logic                  i_update_taken,
    input  logic                  i_update_predicted,
    output logic [HIST_BITS-1:0]  o_ghr,
    output logic [STAT_BITS-1:0]  o_update_count,
    output logic [STAT_BITS-1:0]  o_mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [COUNTER_BITS-1:0] CTR_INIT = COUNTER_BITS'((1 << (COUNTER_BITS - 1)) - 1);
    localparam logic [COUNTER_BITS-1:0] CTR_MAX  = '1;
    localparam logic [INDEX_BITS-1:0]   PTR_LAST = '1;
    localparam logic [STAT_BITS-1:0]    STAT_MAX = '1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [INDEX_BITS-1:0]   r_sweepPtr;
    logic [HIST_BITS-1:0]    r_ghr;
    logic [STAT_BITS-1:0]    r_updCount;
    logic [STAT_BITS-1:0]    r_misCount;
    logic [COUNTER_BITS-1:0] r_table [ENTRIES];

    logic [INDEX_BITS-1:0]   w_histIdx;
    logic [INDEX_BITS-1:0]   w_lookupIdx;
    logic [INDEX_BITS-1:0]   w_updateIdx;
    logic                    w_accept;
    logic [COUNTER_BITS-1:0] w_updCtr;
    logic [COUNTER_BITS-1:0] w_newCtr;
    logic [HIST_BITS-1:0]    w_ghrNext;
    logic                    w_unusedPcBits;

    // Only the low PC bits select a table entry; higher bits alias by design.
    assign w_unusedPcBits = ^{i_lookup_pc[PC_WIDTH-1:INDEX_BITS], i_update_pc[PC_WIDTH-1:INDEX_BITS]};

    // Index generation and counter training. Both lookup and update use the
    // history as it stands before this cycle's update, so an update indexes
    // the same entry the matching lookup did. A flush drops the update.
    always_comb begin
        w_histIdx   = (MODE == 1) ? INDEX_BITS'(r_ghr) : '0;
        w_lookupIdx = i_lookup_pc[INDEX_BITS-1:0] ^ w_histIdx;
        w_updateIdx = i_update_pc[INDEX_BITS-1:0] ^ w_histIdx;
        w_accept    = (r_state == ST_RUN) && i_update_valid && !i_flush;
        w_updCtr    = r_table[w_updateIdx];
        w_newCtr    = w_updCtr;
        if (i_update_taken) begin
            if (w_updCtr != CTR_MAX) begin
                w_newCtr = w_updCtr + COUNTER_BITS'(1);
            end
        end else begin
            if (w_updCtr != '0) begin
                w_newCtr = w_updCtr - COUNTER_BITS'(1);
            end
        end
        w_ghrNext = HIST_BITS'({r_ghr, i_update_taken});
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next state: a flush always restarts the sweep; the sweep ends once
    // the last table entry has been written.
    always_comb begin
        w_nextState = r_state;
        if (i_flush) begin
            w_nextState = ST_INIT;
        end else if ((r_state == ST_INIT) && (r_sweepPtr == PTR_LAST)) begin
            w_nextState = ST_RUN;
        end
    end

    // FSM outputs: no prediction is trusted until the table is initialised.
    // No bypass from a same-cycle update; the new counter shows next cycle.
    always_comb begin
        o_ready      = (r_state == ST_RUN);
        o_prediction = o_ready && r_table[w_lookupIdx][COUNTER_BITS-1];
    end

    // Sweep pointer walks every entry while initialising.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sweepPtr <= '0;
        end else if (i_flush) begin
            r_sweepPtr <= '0;
        end else if (r_state == ST_INIT) begin
            r_sweepPtr <= r_sweepPtr + INDEX_BITS'(1);
        end
    end

    // Global history shifts in every accepted outcome, even in bimodal mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ghr <= '0;
        end else if (i_flush) begin
            r_ghr <= '0;
        end else if (w_accept) begin
            r_ghr <= w_ghrNext;
        end
    end

    // Statistics saturate instead of wrapping; clear wins over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_updCount <= '0;
            r_misCount <= '0;
        end else if (i_clear_stats) begin
            r_updCount <= '0;
            r_misCount <= '0;
        end else if (w_accept) begin
            if (r_updCount != STAT_MAX) begin
                r_updCount <= r_updCount + STAT_BITS'(1);
            end
            if ((i_update_predicted != i_update_taken) && (r_misCount != STAT_MAX)) begin
                r_misCount <= r_misCount + STAT_BITS'(1);
            end
        end
    end

    // Counter table has no reset; the init sweep gives it a known state
    // before o_ready allows it to be used.
    always_ff @(posedge clk) begin
        if (!i_flush) begin
            if (r_state == ST_INIT) begin
                r_table[r_sweepPtr] <= CTR_INIT;
            end else if (w_accept) begin
                r_table[w_updateIdx] <= w_newCtr;
            end
        end
    end

    assign o_ghr              = r_ghr;
    assign o_update_count     = r_updCount;
    assign o_mispredict_count = r_misCount;

endmodule
